legv8_wb_queue: RTL and testbench
=================================

Name: legv8_wb_queue

Overview:
- In-order writeback queue that drives the single write port of the LEGv8 register file: RegWrite, WR, WD.
- Execute stage enqueues one writeback request per instruction.
  - ALU results carry their data at enqueue.
  - Loads reserve a slot; the data memory returns the value later.
- Entries commit strictly in program order, one per cycle, so the register file sees a single serialized write stream.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 2.
- DATA_W, 64, register data width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enq_valid  input  1  execute stage presents a writeback request.
- enq_ready  output  1  queue can accept a request this cycle.
- enq_rd  input  5  destination register number.
- enq_is_load  input  1  1 = data arrives later on ld_*; 0 = data is enq_data.
- enq_data  input  DATA_W  ALU result; ignored when enq_is_load=1.
- ld_valid  input  1  load data return strobe; loads return in program order.
- ld_data  input  DATA_W  returned load value.
- RegWrite  output  1  register file write enable (registered).
- WR  output  5  register file write address (registered).
- WD  output  DATA_W  register file write data (registered).
- count  output  $clog2(DEPTH)+1  current occupancy.
- ld_err  output  1  sticky: ld_valid arrived with no load awaiting data.

Behaviour:
- Reset:
  - Synchronous: on a rising edge with rst=1, clear count, pointers and all entry ready bits.
  - RegWrite=0, WR=0, WD=0, ld_err=0.
  - In-flight entries and any pending load data are discarded.
- Entry state: {rd, is_load, ready, data}.
  - ALU entry: enqueued with ready=1.
  - Load entry: enqueued with ready=0.
- Enqueue:
  - enq_ready = (count < DEPTH); purely from registered count, with no full-cycle pass-through.
  - A request is accepted on an edge where enq_valid && enq_ready.
  - It is written at the tail and the tail pointer wraps modulo DEPTH.
- Load fill:
  - On an edge with ld_valid=1, the oldest stored entry with is_load=1 && ready=0 takes data=ld_data and ready=1.
  - A load accepted on the same edge is not eligible for that strobe.
  - If no entry is waiting, the strobe is dropped and ld_err is set; ld_err stays set until rst.
- Commit:
  - On each edge, if count>0 and the head entry is ready, pop the head.
  - On that same edge register WR=head.rd, WD=head.data, RegWrite=(head.rd != 31).
  - Otherwise register RegWrite=0; WR and WD hold their previous values.
  - XZR (X31) entries are popped, but the register file write is suppressed.
- Latency: an ALU request accepted on edge E is popped on edge E+1; RegWrite is high during the cycle after E+1.
- Ordering:
  - A non-ready load at the head blocks all younger ready ALU entries.
  - At most one commit per cycle.
- Simultaneous events:
  - Enqueue, load fill and commit may all occur on one edge.
  - count_next = count + accepted − popped.
  - A load filled on edge E can commit on edge E+1 at the earliest, never on E.
- Full: count=DEPTH forces enq_ready=0 even if a commit occurs that edge; enq_ready rises the cycle after.
- Empty: count=0 gives RegWrite=0 on the next edge.
- rst asserted mid-stream: takes priority over enqueue, fill and commit on that edge.

Optional Feature:
- Macro: LEGV8_WBQ_SCOREBOARD_EN.
- Defined:
  - Adds output busy [31:0], combinational from queue state.
  - busy[r]=1 iff any queued entry (count-valid slots) has rd=r and r≠31; busy[31] is always 0.
  - Used by the hazard unit to stall reads of pending registers.
- Undefined: the busy port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then enqueue ALU {rd=3, data=64'h1234} → RegWrite=1, WR=3, WD=64'h1234 exactly one cycle after the pop edge; then RegWrite=0; count returns to 0.
- Enqueue load rd=5, then ALU rd=6 data=7; hold ld_valid=0 for 3 cycles → no RegWrite, count=2. Then ld_valid with ld_data=64'hAA → writes in order: (5, 0xAA) then (6, 7) on consecutive cycles.
- Enqueue DEPTH loads with no returns → enq_ready=0 at count=4 and a 5th request is not accepted. Return 4 load values → 4 consecutive writes in order; enq_ready returns to 1.
- Enqueue ALU rd=31 data=0xFF → entry pops and count decrements, but RegWrite stays 0.
- ld_valid with empty queue → ld_err=1 and it stays 1 through later traffic; rst clears it. Assert rst with 3 entries queued → count=0, RegWrite=0 next cycle, no writes afterwards.
- With LEGV8_WBQ_SCOREBOARD_EN defined: enqueue load rd=9 → busy[9]=1; return its data and commit → busy[9]=0. Enqueue rd=31 → busy stays 0.

Source files
------------

// File: rtl/legv8_wb_queue.sv
// legv8_wb_queue: in-order writeback queue feeding the LEGv8 register file write port.
// Optional busy scoreboard output enabled by defining LEGV8_WBQ_SCOREBOARD_EN.
module legv8_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [4:0]              enq_rd,
    input  logic                    enq_is_load,
    input  logic [DATA_W-1:0]       enq_data,
    input  logic                    ld_valid,
    input  logic [DATA_W-1:0]       ld_data,
    output logic                    RegWrite,
    output logic [4:0]              WR,
    output logic [DATA_W-1:0]       WD,
    output logic [$clog2(DEPTH):0]  count,
`ifdef LEGV8_WBQ_SCOREBOARD_EN
    output logic [31:0]             busy,
`endif
    output logic                    ld_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]        rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  is_load_q;
    logic [DEPTH-1:0]  ready_q;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          do_enq;
    logic          do_pop;
    logic          fill_hit;
    logic [AW-1:0] fill_idx;

    assign enq_ready = (count < CW'(DEPTH));
    assign do_enq    = enq_valid && enq_ready;
    assign do_pop    = (count != '0) && ready_q[head];

    // Locate the oldest stored load still waiting for its data.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!fill_hit && (i < int'(count))
                && is_load_q[head + AW'(i)]
                && !ready_q[head + AW'(i)]) begin
                fill_hit = 1'b1;
                fill_idx = head + AW'(i);
            end
        end
    end

    // Pointers, occupancy, ready/kind flags and the sticky load error.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ready_q   <= '0;
            is_load_q <= '0;
            ld_err    <= 1'b0;
        end else begin
            if (do_enq) begin
                is_load_q[tail] <= enq_is_load;
                ready_q[tail]   <= !enq_is_load;
                tail            <= tail + AW'(1);
            end
            if (ld_valid) begin
                if (fill_hit) begin
                    ready_q[fill_idx] <= 1'b1;
                end else begin
                    ld_err <= 1'b1;
                end
            end
            if (do_pop) begin
                head <= head + AW'(1);
            end
            count <= count + CW'(do_enq) - CW'(do_pop);
        end
    end

    // Entry payload; validity is tracked by count and ready_q, so no reset.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            rd_q[tail]   <= enq_rd;
            data_q[tail] <= enq_data;
        end
        if (ld_valid && fill_hit) begin
            data_q[fill_idx] <= ld_data;
        end
    end

    // Registered register-file write port; XZR pops without writing.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite <= 1'b0;
            WR       <= '0;
            WD       <= '0;
        end else if (do_pop) begin
            RegWrite <= (rd_q[head] != 5'd31);
            WR       <= rd_q[head];
            WD       <= data_q[head];
        end else begin
            RegWrite <= 1'b0;
        end
    end

`ifdef LEGV8_WBQ_SCOREBOARD_EN
    // Mark destination registers of every queued entry as pending.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                busy[rd_q[head + AW'(i)]] = 1'b1;
            end
        end
        busy[31] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_legv8_wb_queue.sv
// tb_legv8_wb_queue: directed bench with a queue-based reference model.
// Busy checks are included when LEGV8_WBQ_SCOREBOARD_EN is defined.
module tb_legv8_wb_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    logic              clk;
    logic              rst;
    logic              enq_valid;
    logic              enq_ready;
    logic [4:0]        enq_rd;
    logic              enq_is_load;
    logic [DATA_W-1:0] enq_data;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              RegWrite;
    logic [4:0]        WR;
    logic [DATA_W-1:0] WD;
    logic [2:0]        count;
    logic              ld_err;
`ifdef LEGV8_WBQ_SCOREBOARD_EN
    logic [31:0]       busy;
`endif

    legv8_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .rst(rst),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_rd(enq_rd),
        .enq_is_load(enq_is_load),
        .enq_data(enq_data),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .RegWrite(RegWrite),
        .WR(WR),
        .WD(WD),
        .count(count),
`ifdef LEGV8_WBQ_SCOREBOARD_EN
        .busy(busy),
`endif
        .ld_err(ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        bit          is_load;
        bit          ready;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          m_rw;
    logic [4:0]  m_wr;
    logic [63:0] m_wd;
    bit          m_err;
    bit          chk_on;
    int          n_chk;
    int          n_fail;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one edge of the queue's architectural behaviour.
    task automatic model_step(input bit r, input bit ev, input logic [4:0] rd,
                              input bit il, input logic [63:0] d,
                              input bit lv, input logic [63:0] ldd);
        bit   acc;
        bit   pop;
        bit   found;
        ent_t e;
        ent_t h;
        if (r) begin
            mq.delete();
            m_rw  = 0;
            m_wr  = '0;
            m_wd  = '0;
            m_err = 0;
            return;
        end
        acc = ev && (mq.size() < DEPTH);
        pop = (mq.size() > 0) && mq[0].ready;
        if (lv) begin
            found = 0;
            for (int i = 0; i < mq.size(); i++) begin
                if (!found && mq[i].is_load && !mq[i].ready) begin
                    e = mq[i];
                    e.ready = 1;
                    e.data = ldd;
                    mq[i] = e;
                    found = 1;
                end
            end
            if (!found) m_err = 1;
        end
        if (pop) begin
            h = mq.pop_front();
            m_rw = (h.rd != 5'd31);
            m_wr = h.rd;
            m_wd = h.data;
        end else begin
            m_rw = 0;
        end
        if (acc) begin
            e.rd = rd;
            e.is_load = il;
            e.ready = !il;
            e.data = il ? 64'h0 : d;
            mq.push_back(e);
        end
    endtask

    task automatic cyc(input bit r, input bit ev, input logic [4:0] rd,
                       input bit il, input logic [63:0] d,
                       input bit lv, input logic [63:0] ldd);
        rst = r;
        enq_valid = ev;
        enq_rd = rd;
        enq_is_load = il;
        enq_data = d;
        ld_valid = lv;
        ld_data = ldd;
        @(posedge clk);
        model_step(r, ev, rd, il, d, lv, ldd);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 5'd0, 0, 64'h0, 0, 64'h0);
    endtask

    task automatic enq_alu(input logic [4:0] rd, input logic [63:0] d);
        cyc(0, 1, rd, 0, d, 0, 64'h0);
    endtask

    task automatic enq_ld(input logic [4:0] rd);
        cyc(0, 1, rd, 1, 64'hDEAD, 0, 64'h0);
    endtask

    task automatic ret(input logic [63:0] d);
        cyc(0, 0, 5'd0, 0, 64'h0, 1, d);
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("RegWrite", 64'(RegWrite), 64'(m_rw));
            chk("WR", 64'(WR), 64'(m_wr));
            chk("WD", WD, m_wd);
            chk("count", 64'(count), 64'(mq.size()));
            chk("enq_ready", 64'(enq_ready), 64'(mq.size() < DEPTH));
            chk("ld_err", 64'(ld_err), 64'(m_err));
`ifdef LEGV8_WBQ_SCOREBOARD_EN
            begin
                logic [31:0] eb;
                eb = '0;
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].rd != 5'd31) eb[mq[i].rd] = 1'b1;
                chk("busy", 64'(busy), 64'(eb));
            end
`endif
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        chk_on = 0;
        m_rw = 0;
        m_wr = '0;
        m_wd = '0;
        m_err = 0;

        cyc(1, 0, 5'd0, 0, 64'h0, 0, 64'h0);
        cyc(1, 0, 5'd0, 0, 64'h0, 0, 64'h0);
        chk_on = 1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rw", 64'(RegWrite), 64'd0);
        chk("rst_ready", 64'(enq_ready), 64'd1);

        // ALU writeback latency
        enq_alu(5'd3, 64'h1234);
        chk("alu_rw_early", 64'(RegWrite), 64'd0);
        idle();
        chk("alu_rw", 64'(RegWrite), 64'd1);
        chk("alu_wr", 64'(WR), 64'd3);
        chk("alu_wd", WD, 64'h1234);
        chk("alu_cnt", 64'(count), 64'd0);
        idle();
        chk("alu_rw_off", 64'(RegWrite), 64'd0);

        // Load at head blocks younger ALU; fill + enqueue on one edge
        enq_ld(5'd5);
        enq_alu(5'd6, 64'd7);
        idle();
        idle();
        idle();
        chk("blk_rw", 64'(RegWrite), 64'd0);
        chk("blk_cnt", 64'(count), 64'd2);
        cyc(0, 1, 5'd8, 0, 64'd9, 1, 64'hAA);
        chk("fill_no_commit", 64'(RegWrite), 64'd0);
        chk("fill_cnt", 64'(count), 64'd3);
        idle();
        chk("ld_wr", 64'(WR), 64'd5);
        chk("ld_wd", WD, 64'hAA);
        idle();
        chk("ord_wr", 64'(WR), 64'd6);
        chk("ord_wd", WD, 64'd7);
        idle();
        idle();

        // Full queue of loads
        for (int i = 0; i < DEPTH; i++) enq_ld(5'(10 + i));
        chk("full_cnt", 64'(count), 64'd4);
        chk("full_ready", 64'(enq_ready), 64'd0);
        enq_ld(5'd20);
        chk("full_reject", 64'(count), 64'd4);
        ret(64'd100);
        cyc(0, 1, 5'd21, 0, 64'h55, 1, 64'd101);
        chk("full_pop_wr", 64'(WR), 64'd10);
        chk("full_pop_wd", WD, 64'd100);
        chk("full_pop_cnt", 64'(count), 64'd3);
        chk("full_ready_back", 64'(enq_ready), 64'd1);
        ret(64'd102);
        ret(64'd103);
        idle();
        chk("full_last_wr", 64'(WR), 64'd13);
        chk("full_last_wd", WD, 64'd103);
        idle();
        chk("full_drain", 64'(count), 64'd0);

        // XZR entry
        enq_alu(5'd31, 64'hFF);
        chk("xzr_cnt1", 64'(count), 64'd1);
        idle();
        chk("xzr_cnt0", 64'(count), 64'd0);
        chk("xzr_rw", 64'(RegWrite), 64'd0);

        // Stray strobe with a same-edge load; sticky error; reset mid-stream
        cyc(0, 1, 5'd12, 1, 64'h0, 1, 64'h77);
        chk("err_set", 64'(ld_err), 64'd1);
        chk("err_cnt", 64'(count), 64'd1);
        idle();
        enq_alu(5'd7, 64'd1);
        idle();
        chk("err_sticky", 64'(ld_err), 64'd1);
        enq_ld(5'd14);
        chk("pre_rst_cnt", 64'(count), 64'd3);
        cyc(1, 1, 5'd2, 0, 64'h9, 1, 64'h1);
        chk("rst_cnt2", 64'(count), 64'd0);
        chk("rst_rw2", 64'(RegWrite), 64'd0);
        chk("rst_err", 64'(ld_err), 64'd0);
        idle();
        idle();
        idle();
        chk("post_rst_rw", 64'(RegWrite), 64'd0);

`ifdef LEGV8_WBQ_SCOREBOARD_EN
        enq_ld(5'd9);
        chk("busy9_set", 64'(busy[9]), 64'd1);
        ret(64'h42);
        idle();
        chk("busy9_clr", 64'(busy[9]), 64'd0);
        enq_alu(5'd31, 64'hFF);
        chk("busy31", 64'(busy), 64'd0);
        idle();
`endif
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
